// File: rtl/i2c_target_rx_if.sv
// Bus-side and stream-side signals of the I2C write receiver.
// slave = the receiver itself; master = the pads plus the byte consumer.
interface i2c_target_rx_if;
    logic       scl_in;
    logic       sda_in;
    logic       scl_hold;
    logic       sda_pull;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       addressed;
    logic       busy;

    // Stream: a byte moves on any clk edge where rx_valid && rx_ready; rx_data is stable while rx_valid=1.
    modport slave (
        input  scl_in, sda_in, rx_ready,
        output scl_hold, sda_pull, rx_data, rx_valid, addressed, busy
    );

    modport master (
        output scl_in, sda_in, rx_ready,
        input  scl_hold, sda_pull, rx_data, rx_valid, addressed, busy
    );
endinterface

// File: rtl/i2c_target_rx.sv
// Target-side I2C write receiver: address match, ACK, byte stream out,
// and SCL stretching while the consumer is not ready.
module i2c_target_rx #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_target_rx_if.slave        bus,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_DATA     = 3'd3,
        S_DATA_ACK = 3'd4,
        S_HOLD     = 3'd5,
        S_IGNORE   = 3'd6
    } state_e;

    state_e     state_q, state_d;
    logic       scl_s1_q, scl_s2_q, scl_prev_q;
    logic       sda_s1_q, sda_s2_q, sda_prev_q;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       sda_pull_q, sda_pull_d;
    logic       scl_hold_q, scl_hold_d;
    logic       addressed_q, addressed_d;
    logic       busy_q, busy_d;

    logic scl_rise, scl_fall, start_det, stop_det, handshake, can_load;

    // Synchronizers idle high so a reset never fabricates a bus event.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_s1_q   <= bus.scl_in;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= bus.sda_in;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q & scl_prev_q;
    assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
    assign handshake = rx_valid_q & bus.rx_ready;
    assign can_load  = ~rx_valid_q | bus.rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            sda_pull_q  <= 1'b0;
            scl_hold_q  <= 1'b0;
            addressed_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            sda_pull_q  <= sda_pull_d;
            scl_hold_q  <= scl_hold_d;
            addressed_q <= addressed_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        sda_pull_d  = sda_pull_q;
        scl_hold_d  = scl_hold_q;
        addressed_d = addressed_q;
        busy_d      = busy_q;

        // Handshake completes regardless of bus events; a same-cycle load below re-sets rx_valid.
        if (handshake) rx_valid_d = 1'b0;

        if (start_det) begin
            state_d     = S_ADDR;
            cnt_d       = 4'd0;
            shift_d     = 8'h00;
            busy_d      = 1'b1;
            addressed_d = 1'b0;
            sda_pull_d  = 1'b0;
            scl_hold_d  = 1'b0;
        end else if (stop_det) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            addressed_d = 1'b0;
            sda_pull_d  = 1'b0;
            scl_hold_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s2_q};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (shift_q[7:1] == ADDR && !shift_q[0]) begin
                            sda_pull_d  = 1'b1;
                            addressed_d = 1'b1;
                            state_d     = S_ADDR_ACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        sda_pull_d = 1'b0;
                        cnt_d      = 4'd0;
                        shift_d    = 8'h00;
                        state_d    = S_DATA;
                    end
                end
                S_DATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s2_q};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (can_load) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_pull_d = 1'b1;
                            state_d    = S_DATA_ACK;
                        end else begin
                            scl_hold_d = 1'b1;
                            state_d    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // ACK and hold release land on the same edge, so SDA is low before SCL can rise.
                    if (can_load) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        sda_pull_d = 1'b1;
                        scl_hold_d = 1'b0;
                        state_d    = S_DATA_ACK;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.scl_hold  = scl_hold_q;
    assign bus.sda_pull  = sda_pull_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.addressed = addressed_q;
    assign bus.busy      = busy_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: an open-drain bus master model, a byte consumer,
// and an expected-byte queue derived from address/write rules.
module tb_i2c_target_rx;

    localparam int Q = 20;
    localparam int WAIT_MAX = 5000;

    logic       clk;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic [2:0] state_dbg;

    i2c_target_rx_if bus ();

    // Wired-AND bus: either side can pull a line low.
    assign bus.scl_in = scl_m & ~bus.scl_hold;
    assign bus.sda_in = sda_m & ~bus.sda_pull;

    i2c_target_rx #(.ADDR(7'h50)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .state_o (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_a [0:255];
    int got_n     = 0;
    int hold_cnt  = 0;
    int pull_cnt  = 0;
    int valid_cnt = 0;
    int addr_cnt  = 0;

    always @(negedge clk) begin
        if (!rst && bus.rx_valid && bus.rx_ready) begin
            got_a[got_n[7:0]] = bus.rx_data;
            got_n++;
        end
        if (bus.scl_hold)  hold_cnt++;
        if (bus.sda_pull)  pull_cnt++;
        if (bus.rx_valid)  valid_cnt++;
        if (bus.addressed) addr_cnt++;
    end

    function automatic bit is_our_write(input logic [7:0] a);
        return (a[7:1] == 7'h50) && (a[0] == 1'b0);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_scl_high();
        int i;
        i = 0;
        while (bus.scl_in !== 1'b1 && i < WAIT_MAX) begin
            tick(1);
            i++;
        end
        if (bus.scl_in !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL scl_release_timeout: scl=%b required 1", bus.scl_in);
        end
    endtask

    task automatic send_bit(input logic b, output logic sampled);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        wait_scl_high();
        tick(Q);
        sampled = bus.sda_in;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        wait_scl_high();
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        wait_scl_high();
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        compared += 6;
        if (bus.scl_hold !== 1'b0)  begin mismatched++; $display("FAIL reset_scl_hold: got %b want 0", bus.scl_hold); end
        if (bus.sda_pull !== 1'b0)  begin mismatched++; $display("FAIL reset_sda_pull: got %b want 0", bus.sda_pull); end
        if (bus.rx_data !== 8'h00)  begin mismatched++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
        if (bus.rx_valid !== 1'b0)  begin mismatched++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
        if (bus.addressed !== 1'b0) begin mismatched++; $display("FAIL reset_addressed: got %b want 0", bus.addressed); end
        if (bus.busy !== 1'b0)      begin mismatched++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_two_byte();
        logic ack;
        int base, h0;
        logic [7:0] d [2];
        d[0] = 8'h3C;
        d[1] = 8'hC3;
        base = got_n;
        h0 = hold_cnt;
        exp_q.delete();
        bus.rx_ready = 1'b1;
        i2c_start();
        compared++;
        if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL two_byte_busy_start: got %b want 1", bus.busy); end
        send_byte(8'hA0, ack);
        compared++;
        if (ack !== is_our_write(8'hA0)) begin mismatched++; $display("FAIL two_byte_addr_ack: got %b want %b", ack, is_our_write(8'hA0)); end
        compared++;
        if (bus.addressed !== 1'b1) begin mismatched++; $display("FAIL two_byte_addressed: got %b want 1", bus.addressed); end
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(d[k]);
            send_byte(d[k], ack);
            compared++;
            if (ack !== 1'b1) begin mismatched++; $display("FAIL two_byte_data_ack%0d: got %b want 1", k, ack); end
        end
        i2c_stop();
        tick(8);
        compared += 4;
        if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL two_byte_busy_stop: got %b want 0", bus.busy); end
        if (bus.addressed !== 1'b0) begin mismatched++; $display("FAIL two_byte_addressed_stop: got %b want 0", bus.addressed); end
        if (hold_cnt !== h0) begin mismatched++; $display("FAIL two_byte_no_stretch: got %0d hold cycles want 0", hold_cnt - h0); end
        if (got_n - base !== exp_q.size()) begin mismatched++; $display("FAIL two_byte_count: got %0d want %0d", got_n - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_n - base; i++) begin
            compared++;
            if (got_a[8'(base + i)] !== exp_q[i]) begin mismatched++; $display("FAIL two_byte_data%0d: got %h want %h", i, got_a[8'(base + i)], exp_q[i]); end
        end
    endtask

    task automatic test_mismatch();
        logic ack;
        int p0, v0, a0;
        p0 = pull_cnt;
        v0 = valid_cnt;
        a0 = addr_cnt;
        bus.rx_ready = 1'b1;
        i2c_start();
        send_byte(8'hA2, ack);
        compared++;
        if (ack !== is_our_write(8'hA2)) begin mismatched++; $display("FAIL mismatch_addr_ack: got %b want %b", ack, is_our_write(8'hA2)); end
        send_byte(8'h55, ack);
        compared++;
        if (ack !== 1'b0) begin mismatched++; $display("FAIL mismatch_data_ack: got %b want 0", ack); end
        i2c_stop();
        tick(8);
        compared += 3;
        if (pull_cnt !== p0) begin mismatched++; $display("FAIL mismatch_sda_pull: got %0d pull cycles want 0", pull_cnt - p0); end
        if (valid_cnt !== v0) begin mismatched++; $display("FAIL mismatch_rx_valid: got %0d valid cycles want 0", valid_cnt - v0); end
        if (addr_cnt !== a0) begin mismatched++; $display("FAIL mismatch_addressed: got %0d cycles want 0", addr_cnt - a0); end
    endtask

    task automatic test_stretch();
        logic ack, ack2;
        int base, i;
        base = got_n;
        exp_q.delete();
        bus.rx_ready = 1'b0;
        i2c_start();
        send_byte(8'hA0, ack);
        exp_q.push_back(8'h11);
        send_byte(8'h11, ack);
        tick(2);
        compared += 3;
        if (ack !== 1'b1) begin mismatched++; $display("FAIL stretch_ack_11: got %b want 1", ack); end
        if (bus.rx_valid !== 1'b1) begin mismatched++; $display("FAIL stretch_valid_11: got %b want 1", bus.rx_valid); end
        if (bus.rx_data !== 8'h11) begin mismatched++; $display("FAIL stretch_data_11: got %h want 11", bus.rx_data); end
        exp_q.push_back(8'h22);
        fork
            send_byte(8'h22, ack2);
            begin
                i = 0;
                while (bus.scl_hold !== 1'b1 && i < WAIT_MAX) begin tick(1); i++; end
                compared++;
                if (bus.scl_hold !== 1'b1) begin mismatched++; $display("FAIL stretch_hold_assert: got %b want 1", bus.scl_hold); end
                tick(40);
                compared += 3;
                if (bus.scl_hold !== 1'b1) begin mismatched++; $display("FAIL stretch_hold_kept: got %b want 1", bus.scl_hold); end
                if (bus.scl_in !== 1'b0) begin mismatched++; $display("FAIL stretch_scl_low: got %b want 0", bus.scl_in); end
                if (bus.rx_data !== 8'h11) begin mismatched++; $display("FAIL stretch_data_held: got %h want 11", bus.rx_data); end
                bus.rx_ready = 1'b1;
                tick(1);
                bus.rx_ready = 1'b0;
                compared += 4;
                if (bus.rx_data !== 8'h22) begin mismatched++; $display("FAIL stretch_data_22: got %h want 22", bus.rx_data); end
                if (bus.rx_valid !== 1'b1) begin mismatched++; $display("FAIL stretch_valid_22: got %b want 1", bus.rx_valid); end
                if (bus.sda_pull !== 1'b1) begin mismatched++; $display("FAIL stretch_ack_drive: got %b want 1", bus.sda_pull); end
                if (bus.scl_hold !== 1'b0) begin mismatched++; $display("FAIL stretch_hold_release: got %b want 0", bus.scl_hold); end
            end
        join
        compared++;
        if (ack2 !== 1'b1) begin mismatched++; $display("FAIL stretch_ack_22: got %b want 1", ack2); end
        i2c_stop();
        tick(4);
        bus.rx_ready = 1'b1;
        tick(4);
        compared += 2;
        if (bus.rx_valid !== 1'b0) begin mismatched++; $display("FAIL stretch_drained: got %b want 0", bus.rx_valid); end
        if (got_n - base !== exp_q.size()) begin mismatched++; $display("FAIL stretch_count: got %0d want %0d", got_n - base, exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_n - base; k++) begin
            compared++;
            if (got_a[8'(base + k)] !== exp_q[k]) begin mismatched++; $display("FAIL stretch_data%0d: got %h want %h", k, got_a[8'(base + k)], exp_q[k]); end
        end
    endtask

    task automatic test_abort();
        logic ack, s;
        int base, v0;
        logic [3:0] part;
        base = got_n;
        exp_q.delete();
        bus.rx_ready = 1'b1;
        part = 4'($urandom_range(0, 15));
        i2c_start();
        send_byte(8'hA0, ack);
        v0 = valid_cnt;
        for (int i = 3; i >= 0; i--) send_bit(part[i], s);
        i2c_stop();
        tick(8);
        compared += 4;
        if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        if (bus.sda_pull !== 1'b0) begin mismatched++; $display("FAIL abort_sda_pull: got %b want 0", bus.sda_pull); end
        if (valid_cnt !== v0) begin mismatched++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", valid_cnt - v0); end
        if (got_n !== base) begin mismatched++; $display("FAIL abort_no_byte: got %0d bytes want 0", got_n - base); end
        i2c_start();
        send_byte(8'hA0, ack);
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, ack);
        i2c_stop();
        tick(8);
        compared += 2;
        if (ack !== 1'b1) begin mismatched++; $display("FAIL abort_next_ack: got %b want 1", ack); end
        if (got_n - base !== 1) begin mismatched++; $display("FAIL abort_next_count: got %0d want 1", got_n - base); end
        if (got_n - base >= 1) begin
            compared++;
            if (got_a[8'(base)] !== exp_q[0]) begin mismatched++; $display("FAIL abort_next_data: got %h want %h", got_a[8'(base)], exp_q[0]); end
        end
    endtask

    task automatic test_rep_start();
        logic ack;
        int base;
        base = got_n;
        exp_q.delete();
        bus.rx_ready = 1'b1;
        i2c_start();
        send_byte(8'hA0, ack);
        exp_q.push_back(8'h01);
        send_byte(8'h01, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        compared += 3;
        if (ack !== is_our_write(8'hA1)) begin mismatched++; $display("FAIL rep_read_nack: got %b want %b", ack, is_our_write(8'hA1)); end
        if (bus.addressed !== 1'b0) begin mismatched++; $display("FAIL rep_addressed: got %b want 0", bus.addressed); end
        if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL rep_busy: got %b want 1", bus.busy); end
        send_byte(8'h99, ack);
        compared++;
        if (ack !== 1'b0) begin mismatched++; $display("FAIL rep_ignore_ack: got %b want 0", ack); end
        i2c_stop();
        tick(8);
        compared++;
        if (got_n - base !== 1) begin mismatched++; $display("FAIL rep_count: got %0d want 1", got_n - base); end
        if (got_n - base >= 1) begin
            compared++;
            if (got_a[8'(base)] !== exp_q[0]) begin mismatched++; $display("FAIL rep_data: got %h want %h", got_a[8'(base)], exp_q[0]); end
        end
    endtask

    task automatic test_random();
        logic ack, want_ack;
        logic [7:0] addr, d;
        int base, n;
        bit done;
        base = got_n;
        exp_q.delete();
        done = 1'b0;
        fork
            begin
                for (int t = 0; t < 6; t++) begin
                    addr = ($urandom_range(0, 1) == 1) ? 8'hA0 : 8'($urandom_range(0, 255));
                    n = $urandom_range(1, 3);
                    want_ack = is_our_write(addr);
                    i2c_start();
                    send_byte(addr, ack);
                    compared++;
                    if (ack !== want_ack) begin mismatched++; $display("FAIL random_addr_ack t%0d addr %h: got %b want %b", t, addr, ack, want_ack); end
                    for (int k = 0; k < n; k++) begin
                        d = 8'($urandom_range(0, 255));
                        if (want_ack) exp_q.push_back(d);
                        send_byte(d, ack);
                        compared++;
                        if (ack !== want_ack) begin mismatched++; $display("FAIL random_data_ack t%0d k%0d: got %b want %b", t, k, ack, want_ack); end
                    end
                    i2c_stop();
                end
                done = 1'b1;
            end
            while (!done) begin
                bus.rx_ready = 1'($urandom_range(0, 1));
                tick(1);
            end
        join
        bus.rx_ready = 1'b1;
        tick(10);
        compared++;
        if (got_n - base !== exp_q.size()) begin mismatched++; $display("FAIL random_count: got %0d want %0d", got_n - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_n - base; i++) begin
            compared++;
            if (got_a[8'(base + i)] !== exp_q[i]) begin mismatched++; $display("FAIL random_data%0d: got %h want %h", i, got_a[8'(base + i)], exp_q[i]); end
        end
    endtask

    task automatic test_reset_hold();
        logic ack, ack2;
        int base, i;
        base = got_n;
        bus.rx_ready = 1'b0;
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h33, ack);
        fork
            send_byte(8'h44, ack2);
            begin
                i = 0;
                while (bus.scl_hold !== 1'b1 && i < WAIT_MAX) begin tick(1); i++; end
                compared++;
                if (bus.scl_hold !== 1'b1) begin mismatched++; $display("FAIL rst_hold_reached: got %b want 1", bus.scl_hold); end
                tick(10);
                rst = 1'b1;
                tick(1);
                compared += 3;
                if (bus.scl_hold !== 1'b0) begin mismatched++; $display("FAIL rst_hold_scl_hold: got %b want 0", bus.scl_hold); end
                if (bus.rx_valid !== 1'b0) begin mismatched++; $display("FAIL rst_hold_rx_valid: got %b want 0", bus.rx_valid); end
                if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL rst_hold_busy: got %b want 0", bus.busy); end
                rst = 1'b0;
            end
        join
        i2c_stop();
        bus.rx_ready = 1'b1;
        tick(8);
        compared++;
        if (got_n !== base) begin mismatched++; $display("FAIL rst_hold_dropped: got %0d bytes want 0", got_n - base); end
    endtask

    initial begin
        rst = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        bus.rx_ready = 1'b0;
        test_reset();
        test_two_byte();
        test_mismatch();
        test_stretch();
        test_abort();
        test_rep_start();
        test_random();
        test_reset_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
